rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output and per-channel valid/ready handshakes.
- Two modes: fixed select (sel-driven, the direct successor of the 4:1 datapath mux) and round-robin arbitration across channels.
- Sits between multiple producers and one consumer in the MIPS datapath/debug fabric; the output stage is a single registered entry.

Parameters:
WIDTH, 32, data width of each channel
NUM_IN, 4, number of input channels (2..16)
SEL_W, $clog2(NUM_IN), width of sel and out_src

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  channel i has data
in_ready  output  NUM_IN  channel i transfer accepted this cycle (combinational)
sel  input  SEL_W  channel index used in fixed mode
mode  input  1  0 = fixed select, 1 = round-robin
out_data  output  WIDTH  registered selected data
out_src  output  SEL_W  index of the channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1 (channel 0 has first RR priority). in_ready=0 while in reset.
- can_load = !out_valid || out_ready.
- Fixed mode:
  - grant = sel if sel < NUM_IN, in_valid[sel]=1 and can_load.
  - sel >= NUM_IN grants nothing and never loads an undefined value.
- Round-robin mode:
  - Search channels starting at (rr_ptr+1) mod NUM_IN, wrapping.
  - First channel with in_valid=1 is granted if can_load.
  - On a grant, rr_ptr <= granted index.
  - rr_ptr is unchanged in fixed mode and when there is no grant.
- Handshake:
  - in_ready[g]=1 only for the granted channel; all others are 0. At most one bit of in_ready is set.
  - A transfer occurs on channel g when in_valid[g] && in_ready[g].
  - in_ready must not depend on in_valid of other channels in fixed mode.
- Output register update on a rising edge:
  - Grant: out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - No grant and out_ready && out_valid: out_valid <= 0; out_data/out_src hold.
  - Otherwise hold.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held high; full-rate back-to-back.
- Backpressure:
  - With out_valid=1 and out_ready=0, out_data/out_src/out_valid are stable and all in_ready=0.
- Simultaneous drain+load: when out_ready=1 and out_valid=1 with a new grant in the same cycle, the old word leaves and the new word loads (no bubble).
- Mode or sel changes:
  - Take effect combinationally for the current cycle's grant.
  - Never disturb a word already in the output register.
- Reset mid-transfer: the output word is discarded, out_valid=0 immediately (async), and rr_ptr is reinitialised.
- NUM_IN=2 with SEL_W=1: no out-of-range sel exists.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 asynchronously; after release, first RR grant goes to channel 0 when all valid.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, ch2 data=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEADBEEF, out_src=2, out_valid=1.
- Invalid sel: NUM_IN=3, SEL_W=2, sel=3, in_valid=3'b111 -> in_ready=0 and out_valid stays 0 for 10 cycles.
- Round-robin fairness: mode=1, all 4 valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; in_valid=4'b1010 -> out_src alternates 1,3.
- Backpressure: out_valid=1 with out_src=1, out_ready=0 for 5 cycles -> out_data/out_src stable, in_ready=0; out_ready=1 -> word drains and the next grant loads in the same edge, with no idle cycle.
- Mode switch: RR grants ch1, then switch to mode=0 with sel=0 -> ch0 is granted; switching back to mode=1 resumes the search from ch2 (rr_ptr retained at 1).

Source files
------------

// File: rtl/rr_stream_mux.sv
// N-input stream selector with a single registered output entry.
// Fixed (sel-driven) or round-robin arbitration, valid/ready on both sides.

module rr_stream_mux_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 2
) (
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             gnt,
  input  logic [SEL_W-1:0] gnt_idx,
  output logic             fix_req,
  output logic             in_ready
);
  // Fixed-mode request looks only at this lane's valid, so in_ready never
  // depends on neighbours; an out-of-range sel matches no lane.
  assign fix_req  = in_valid && (sel == SEL_W'(IDX));
  assign in_ready = gnt && (gnt_idx == SEL_W'(IDX));
endmodule

module rr_stream_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);
  logic [NUM_IN-1:0][WIDTH-1:0] ch_data;
  logic [NUM_IN-1:0]            fix_req;
  logic [SEL_W-1:0]             rr_ptr, gnt_idx;
  logic                         gnt_any, gnt, can_load;

  assign ch_data  = in_data;
  assign can_load = !out_valid || out_ready;
  // Gated by rst_n so no handshake completes while reset is asserted.
  assign gnt      = gnt_any && can_load && rst_n;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    rr_stream_mux_lane #(.IDX(i), .SEL_W(SEL_W)) u_lane (
      .in_valid (in_valid[i]),
      .sel      (sel),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .fix_req  (fix_req[i]),
      .in_ready (in_ready[i])
    );
  end

  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    if (mode) begin
      // Search starts just past the last winner and wraps.
      for (int k = 1; k <= NUM_IN; k++) begin
        idx  = (int'(rr_ptr) + k) % NUM_IN;
        cand = SEL_W'(idx);
        if (!gnt_any && in_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end else begin
      gnt_any = |fix_req;
      gnt_idx = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(NUM_IN - 1);
    end else if (gnt) begin
      out_data  <= ch_data[gnt_idx];
      out_src   <= gnt_idx;
      out_valid <= 1'b1;
      if (mode) rr_ptr <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed + random bench for rr_stream_mux against a queue-free behavioural model.
module tb_rr_stream_mux;
  localparam int W = 32, N = 4, SW = 2, N3 = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [SW-1:0]  sel, out_src;
  logic           mode, out_valid, out_ready;
  logic [W-1:0]   out_data;

  logic [N3*W-1:0] in_data3;
  logic [N3-1:0]   in_valid3, in_ready3;
  logic [1:0]      sel3, out_src3;
  logic            mode3, out_valid3, out_ready3;
  logic [W-1:0]    out_data3;

  rr_stream_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready));

  rr_stream_mux #(.WIDTH(W), .NUM_IN(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3));

  int checks = 0, failures = 0;

  // Reference state: what the output register should hold, and the last RR winner.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_src, m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = N - 1;
  endtask

  function automatic int model_grant();
    if (m_valid && !out_ready) return -1;
    if (mode) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (in_valid[c]) return c;
      end
    end else if (int'(sel) < N && in_valid[sel]) begin
      return int'(sel);
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom();
  endtask

  // Entered just after a falling edge with inputs set; leaves at the next falling edge.
  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk({tag, "_rdy"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_data = in_data[g*W +: W]; m_src = g; m_valid = 1;
      if (mode) m_ptr = g;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    chk({tag, "_vld"}, 64'(out_valid), 64'(m_valid));
    chk({tag, "_data"}, 64'(out_data), 64'(m_data));
    chk({tag, "_src"}, 64'(out_src), 64'(m_src));
    @(negedge clk);
  endtask

  initial begin
    in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;
    model_reset();

    // Reset: nothing accepted, outputs cleared.
    repeat (2) @(negedge clk);
    in_valid = '1;
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed select.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; rand_data();
    in_data[2*W +: W] = 32'hDEAD_BEEF;
    cycle("fix");
    chk("fix_data_k", 64'(out_data), 64'hDEAD_BEEF);
    chk("fix_src_k", 64'(out_src), 64'd2);

    // Round-robin fairness, then alternation on a sparse valid pattern.
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_data(); cycle("rr");
      chk("rr_seq", 64'(out_src), 64'(i % 4));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rand_data(); cycle("rr_alt");
      chk("rr_alt_src", 64'(out_src), (i % 2) ? 64'd3 : 64'd1);
    end

    // Backpressure, then drain+load on the same edge.
    in_valid = 4'b0010; rand_data(); cycle("bp_load");
    chk("bp_src0", 64'(out_src), 64'd1);
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_data(); cycle("bp");
      chk("bp_hold_src", 64'(out_src), 64'd1);
    end
    out_ready = 1'b1; rand_data(); cycle("bp_rel");
    chk("bp_rel_src", 64'(out_src), 64'd2);
    chk("bp_rel_vld", 64'(out_valid), 64'd1);

    // Mode switch keeps the RR pointer.
    in_valid = 4'b0010; rand_data(); cycle("ms_rr");
    chk("ms_rr_src", 64'(out_src), 64'd1);
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; rand_data();
    #1 chk("ms_fix_rdy_k", 64'(in_ready), 64'b0001);
    cycle("ms_fix");
    mode = 1'b1; rand_data();
    #1 chk("ms_back_rdy_k", 64'(in_ready), 64'b0100);
    cycle("ms_back");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle("rnd");
    end

    // Asynchronous reset with a word held in the output register.
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0; rand_data();
    cycle("pre_rst");
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_src", 64'(out_src), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; rand_data();
    cycle("post_rst");
    chk("post_rst_src", 64'(out_src), 64'd0);

    // Three-channel instance: sel=3 is out of range and must never load.
    sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; mode3 = 1'b0;
    in_data3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int i = 0; i < 10; i++) begin
      #1 chk("inv_sel_rdy", 64'(in_ready3), 64'd0);
      @(posedge clk);
      #1 chk("inv_sel_vld", 64'(out_valid3), 64'd0);
      @(negedge clk);
    end
    sel3 = 2'd1;
    #1 chk("n3_sel1_rdy", 64'(in_ready3), 64'b010);
    @(posedge clk);
    #1;
    chk("n3_sel1_src", 64'(out_src3), 64'd1);
    chk("n3_sel1_data", 64'(out_data3), 64'h2222_2222);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
